// File: rtl/instrument_display_mux.sv
// Multi-channel instrument readout: samples one channel per update tick, converts it to BCD
// serially (double-dabble, one bit per cycle) and drives active-low 7-segment digits.
module instrument_display_mux #(
  parameter int NUM_CH          = 4,
  parameter int VALUE_W         = 16,
  parameter int DIGITS          = 4,
  parameter int UPDATE_MS       = 100,
  parameter int CLOCK_FREQUENCY = 166000000,
  parameter int CYCLE_UPDATES   = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*VALUE_W-1:0] values,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  input  logic                      auto_cycle,
  input  logic                      blank_lz,
  output logic [DIGITS*7-1:0]       hex,
  output logic [$clog2(NUM_CH)-1:0] ch_shown,
  output logic                      overflow,
  output logic                      busy
);

  localparam int CH_W     = $clog2(NUM_CH);
  localparam int TICK_CYC = CLOCK_FREQUENCY / 1000 * UPDATE_MS;
  localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int CUP_W    = $clog2(CYCLE_UPDATES + 1);
  localparam int BIT_W    = $clog2(VALUE_W + 1);
  // Decimal digits needed for 2**VALUE_W-1 (ceil of VALUE_W*log10(2)), never fewer than DIGITS.
  localparam int NAT_DIG  = (VALUE_W * 30103 + 99999) / 100000;
  localparam int BCD_DIG  = (NAT_DIG > DIGITS) ? NAT_DIG : DIGITS;
  localparam int BCD_W    = 4 * BCD_DIG;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [CUP_W-1:0]     auto_cnt_q, auto_cnt_d;
  logic [CH_W-1:0]      auto_ch_q, auto_ch_d;
  logic [VALUE_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]      pend_ch_q, pend_ch_d;
  logic [DIGITS*7-1:0]  hex_q, hex_d;
  logic [CH_W-1:0]      ch_shown_q, ch_shown_d;
  logic                 overflow_q, overflow_d;

  logic                 tick;
  logic [CH_W-1:0]      src_raw, src_ch;
  logic [VALUE_W-1:0]   src_val;
  logic [BCD_W-1:0]     bcd_adj;
  logic [DIGITS*7-1:0]  hex_new;
  logic                 ovf;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick = (tick_cnt_q == TICK_W'(TICK_CYC - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    auto_cnt_d = auto_cnt_q;
    auto_ch_d  = auto_ch_q;
    if (!auto_cycle) begin
      auto_cnt_d = '0;
    end else if (tick) begin
      // Ticks are counted even when the converter is busy and drops them.
      if (auto_cnt_q == CUP_W'(CYCLE_UPDATES - 1)) begin
        auto_cnt_d = '0;
        auto_ch_d  = (auto_ch_q == CH_W'(NUM_CH - 1)) ? '0 : auto_ch_q + 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    src_raw = auto_cycle ? auto_ch_d : ch_sel;
    src_ch  = (src_raw > CH_W'(NUM_CH - 1)) ? CH_W'(NUM_CH - 1) : src_raw;
    src_val = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (src_ch == CH_W'(k)) src_val = values[k*VALUE_W +: VALUE_W];
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < BCD_DIG; k++) begin
      if (bcd_q[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
    end
  end

  always_comb begin : display_decode
    logic            lead;
    logic [3:0]      nib;
    logic [6:0]      seg;
    int unsigned     i;
    ovf = 1'b0;
    for (int unsigned k = DIGITS; k < BCD_DIG; k++) begin
      ovf = ovf | (|bcd_q[k*4 +: 4]);
    end
    hex_new = '1;
    lead    = 1'b1;
    // Walk from the most significant digit down so leading zeros can be blanked.
    for (int unsigned j = 0; j < DIGITS; j++) begin
      i   = DIGITS - 1 - j;
      nib = bcd_q[i*4 +: 4];
      if (nib != 4'd0 || i == 0) lead = 1'b0;
      if (ovf)                   seg = 7'b0111111;
      else if (blank_lz && lead) seg = 7'h7F;
      else                       seg = seg7(nib);
      hex_new[i*7 +: 7] = seg;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    pend_ch_d  = pend_ch_q;
    hex_d      = hex_q;
    ch_shown_d = ch_shown_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          shift_d   = src_val;
          bcd_d     = '0;
          bit_cnt_d = '0;
          pend_ch_d = src_ch;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d     = (bcd_adj << 1) | BCD_W'(shift_q[VALUE_W-1]);
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(VALUE_W - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        hex_d      = hex_new;
        ch_shown_d = pend_ch_q;
        overflow_d = ovf;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      auto_cnt_q <= '0;
      auto_ch_q  <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      pend_ch_q  <= '0;
      hex_q      <= '1;
      ch_shown_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      auto_cnt_q <= auto_cnt_d;
      auto_ch_q  <= auto_ch_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      pend_ch_q  <= pend_ch_d;
      hex_q      <= hex_d;
      ch_shown_q <= ch_shown_d;
      overflow_q <= overflow_d;
    end
  end

  assign hex      = hex_q;
  assign ch_shown = ch_shown_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_instrument_display_mux.sv
// Directed bench for instrument_display_mux with a 10-cycle update tick.
module tb_instrument_display_mux;

  localparam int NUM_CH  = 4;
  localparam int VALUE_W = 16;
  localparam int DIGITS  = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DS = 7'b0111111;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_CH*VALUE_W-1:0] values;
  logic [1:0]                ch_sel;
  logic                      auto_cycle;
  logic                      blank_lz;
  logic [DIGITS*7-1:0]       hex;
  logic [1:0]                ch_shown;
  logic                      overflow;
  logic                      busy;

  int n_cmp = 0;
  int n_bad = 0;

  instrument_display_mux #(
    .NUM_CH(NUM_CH),
    .VALUE_W(VALUE_W),
    .DIGITS(DIGITS),
    .UPDATE_MS(10),
    .CLOCK_FREQUENCY(1000),
    .CYCLE_UPDATES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .values(values),
    .ch_sel(ch_sel),
    .auto_cycle(auto_cycle),
    .blank_lz(blank_lz),
    .hex(hex),
    .ch_shown(ch_shown),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] hx(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic set_ch(input int k, input logic [15:0] v);
    values[k*VALUE_W +: VALUE_W] = v;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!busy && n < 60);
    if (!busy) check("busy_timeout", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_update();
    int n;
    wait_busy(n);
    repeat (17) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    values     = '0;
    ch_sel     = 2'd2;
    auto_cycle = 1'b0;
    blank_lz   = 1'b0;
    set_ch(2, 16'd1234);

    hold_reset();
    check("rst_hex", hex, hx(BL, BL, BL, BL));
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ch", {30'b0, ch_shown}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b1;
    wait_busy(n);
    check("first_busy_cycles", n, 32'd10);

    // Outputs must still hold one edge before the load completes.
    repeat (16) @(posedge clk);
    #1;
    check("lat_hold_hex", hex, hx(BL, BL, BL, BL));
    check("lat_hold_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("v1234_hex", hex, hx(S1, S2, S3, S4));
    check("v1234_ch", {30'b0, ch_shown}, 32'd2);
    check("v1234_ovf", {31'b0, overflow}, 32'd0);
    check("v1234_busy", {31'b0, busy}, 32'd0);

    set_ch(1, 16'd12345);
    ch_sel = 2'd1;
    wait_update();
    check("v12345_hex", hex, hx(DS, DS, DS, DS));
    check("v12345_ovf", {31'b0, overflow}, 32'd1);
    check("v12345_ch", {30'b0, ch_shown}, 32'd1);

    set_ch(1, 16'd7);
    blank_lz = 1'b1;
    wait_update();
    check("v7_lz_hex", hex, hx(BL, BL, BL, S7));
    check("v7_lz_ovf", {31'b0, overflow}, 32'd0);

    set_ch(1, 16'd0);
    wait_update();
    check("v0_lz_hex", hex, hx(BL, BL, BL, S0));

    set_ch(1, 16'd9999);
    wait_update();
    check("v9999_hex", hex, hx(S9, S9, S9, S9));
    check("v9999_ovf", {31'b0, overflow}, 32'd0);

    set_ch(1, 16'd10000);
    wait_update();
    check("v10000_hex", hex, hx(DS, DS, DS, DS));
    check("v10000_ovf", {31'b0, overflow}, 32'd1);

    set_ch(1, 16'd65535);
    wait_update();
    check("v65535_ovf", {31'b0, overflow}, 32'd1);

    set_ch(1, 16'd100);
    wait_update();
    check("v100_lz_hex", hex, hx(BL, S1, S0, S0));

    // Inputs changed mid-conversion must not affect the result in flight.
    blank_lz = 1'b0;
    set_ch(0, 16'd100);
    set_ch(3, 16'd4321);
    ch_sel = 2'd0;
    wait_busy(n);
    repeat (5) @(posedge clk);
    #1;
    ch_sel = 2'd3;
    set_ch(0, 16'd999);
    repeat (12) @(posedge clk);
    #1;
    check("midconv_hex", hex, hx(S0, S1, S0, S0));
    check("midconv_ch", {30'b0, ch_shown}, 32'd0);
    wait_update();
    check("next_ch3_hex", hex, hx(S4, S3, S2, S1));
    check("next_ch3_ch", {30'b0, ch_shown}, 32'd3);

    // Reset during the fifth conversion cycle.
    set_ch(1, 16'd58);
    ch_sel   = 2'd1;
    blank_lz = 1'b1;
    wait_busy(n);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hex", hex, hx(BL, BL, BL, BL));
    check("abort_ch", {30'b0, ch_shown}, 32'd0);
    check("abort_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b1;
    wait_busy(n);
    check("abort_busy_cycles", n, 32'd10);
    repeat (17) @(posedge clk);
    #1;
    check("abort_next_hex", hex, hx(BL, BL, S5, S8));
    check("abort_next_ch", {30'b0, ch_shown}, 32'd1);

    // Auto-cycle: conversions take every other tick, and every tick advances the counter.
    auto_cycle = 1'b1;
    blank_lz   = 1'b1;
    ch_sel     = 2'd0;
    set_ch(0, 16'd10);
    set_ch(1, 16'd11);
    set_ch(2, 16'd12);
    set_ch(3, 16'd13);
    hold_reset();
    reset = 1'b1;
    wait_update();
    check("auto1_ch", {30'b0, ch_shown}, 32'd0);
    check("auto1_hex", hex, hx(BL, BL, S1, S0));
    wait_update();
    check("auto2_ch", {30'b0, ch_shown}, 32'd1);
    wait_update();
    check("auto3_ch", {30'b0, ch_shown}, 32'd2);
    check("auto3_hex", hex, hx(BL, BL, S1, S2));
    auto_cycle = 1'b0;
    ch_sel     = 2'd1;
    wait_update();
    check("manual_ch", {30'b0, ch_shown}, 32'd1);
    auto_cycle = 1'b1;
    wait_update();
    check("auto_held_ch", {30'b0, ch_shown}, 32'd3);
    check("auto_held_hex", hex, hx(BL, BL, S1, S3));
    wait_update();
    check("auto_wrap_ch", {30'b0, ch_shown}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
